mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Responder for the MEM-stage strobe of the multi-cycle core. It accepts one load/store request per instruction from the stage controller, drives a byte-strobed synchronous data RAM, and performs lane alignment and sign/zero extension. It returns a one-cycle `done` pulse with load data or an error flag. It sits between the EX/MEM pipeline register and the data BRAM, and `busy` lets the controller hold in the MEM stage.

## Interface
- `RD_LATENCY`, default 1: cycles from `ram_en` high to valid `ram_rdata`; legal range 1..4.
- `WADDR_W`, default 14: RAM word-address width.
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  one clock; reset is asynchronous and active-low.
- `req`  in  1  single-cycle request strobe.
- `we`  in  1  1 = store, 0 = load; sampled with `req`.
- `funct3`  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, right-aligned.
- `busy`  out  1  high from the cycle after `req` is accepted until `done`, inclusive.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid only with `done`: misaligned or illegal `funct3`.
- `rdata`  out  32  extended load result; holds its value until the next successful load.
- `ram_en`  out  1  RAM access enable.
- `ram_we`  out  4  byte write strobes.
- `ram_addr`  out  WADDR_W  word address, `addr[WADDR_W+1:2]`.
- `ram_wdata`  out  32  lane-replicated store data.
- `ram_rdata`  in  32  RAM read data.

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE. Every output is a register.
- IDLE with `req`=1: latch `we`, `funct3`, `addr[1:0]`. Check legality:
  - Illegal: `funct3` in {011, 110, 111}, a store with `funct3` 100 or 101, H with `addr[0]`=1, or W with `addr[1:0]`≠0.
  - Illegal → go to DONE with `err`=1. There is no RAM access.
  - Legal → go to ACCESS.
- ACCESS: `ram_en`=1 for exactly this cycle.
  - Store `ram_we`: SB = 0001<<`addr[1:0]`; SH = 0011<<`addr[1:0]`; SW = 1111.
  - Store `ram_wdata`: SB = {4{wdata[7:0]}}; SH = {2{wdata[15:0]}}; SW = wdata.
  - Load: `ram_we`=0000.
  - Store → DONE. Load → WAIT, with the counter loaded to `RD_LATENCY`-1.
- WAIT: decrement the counter. At zero, capture the extracted lane and go to DONE.
  - Lane extraction: shift `ram_rdata` right by 8×`addr[1:0]`.
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- DONE: `done`=1 and `err` valid, then go to IDLE.
- `req` is ignored outside IDLE and has no side effects.
- `ram_we`, `ram_en` and `ram_wdata` return to 0 in every cycle outside ACCESS.
- `rdata` is not updated on stores or on errors.

## Timing
- Reset, asynchronous: state IDLE, counter 0. All outputs are 0, including `rdata`, `ram_addr` and `ram_wdata`.
- In the timing below, `req` is sampled at edge 0.
  - Error case: `done`/`err` high in cycle 1.
  - Store: `ram_en`/`ram_we` in cycle 1, `done` in cycle 2.
  - Load: `ram_en` in cycle 1, `ram_rdata` sampled at the end of cycle `1+RD_LATENCY`, `done` and new `rdata` in cycle `2+RD_LATENCY`.
- `busy` = (state ≠ IDLE).
- Back-to-back: a new `req` is accepted in the cycle after `done`, giving a minimum spacing of 3 cycles for a store.
- Reset asserted mid-access: abort immediately. No `done` is produced. `ram_en`/`ram_we` drop asynchronously, and the bench checks that no partial write strobe persists.

## Test plan
- Reset: assert `reset_n`=0 during WAIT → all outputs 0 at once; after release, `busy`=0 and no `done`.
- SB `addr`=0x1003, `wdata`=0x000000A5 → cycle 1 `ram_we`=1000, `ram_wdata`=0xA5A5A5A5, `ram_addr`=0x400; `done` in cycle 2, `err`=0.
- LB / LBU / LH, with `RD_LATENCY`=2:
  - LB `addr`=0x1003, `ram_rdata`=0x80FF7F01 → `rdata`=0xFFFFFF80, `done` in cycle 4.
  - LBU at the same address → 0x00000080.
  - LH `addr`=0x1002 → 0xFFFF80FF.
- Misaligned LW `addr`=0x1002 → `done`/`err` in cycle 1, `ram_en` never high, `rdata` unchanged.
- `req` pulsed in every cycle during a load → exactly one `ram_en` and one `done`. The next request, issued the cycle after `done`, completes normally.
- Illegal `funct3`=011 load and SBU (`we`=1, `funct3`=100) → `err`=1, no RAM activity.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store responder: drives a byte-strobed synchronous data RAM,
// aligns load/store lanes and sign/zero-extends loads. All outputs are registered.
module mem_access_unit #(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned WADDR_W    = 14
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req,
  input  logic               we,
  input  logic [2:0]         funct3,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [31:0]        rdata,
  output logic               ram_en,
  output logic [3:0]         ram_we,
  output logic [WADDR_W-1:0] ram_addr,
  output logic [31:0]        ram_wdata,
  input  logic [31:0]        ram_rdata
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  localparam logic [1:0] LatM1 = 2'(RD_LATENCY - 1);

  logic [1:0]         state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               we_q;
  logic [2:0]         f3_q;
  logic [1:0]         off_q;
  logic               illegal;
  logic               accept;
  logic [3:0]         ram_we_d;
  logic [31:0]        ram_wdata_d;
  logic [31:0]        shifted;
  logic [31:0]        ext;
  logic [31:0]        rdata_d;
  logic [WADDR_W-1:0] ram_addr_d;

  always_comb begin
    illegal = 1'b0;
    case (funct3)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = addr[0];
      3'b010:  illegal = (addr[1:0] != 2'b00);
      3'b100:  illegal = we;
      3'b101:  illegal = we | addr[0];
      default: illegal = 1'b1;
    endcase
  end

  assign accept = (state_q == StIdle) && req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (req) state_d = illegal ? StDone : StAccess;
      end
      StAccess: begin
        if (we_q) begin
          state_d = StDone;
        end else begin
          state_d = StWait;
          cnt_d   = LatM1;
        end
      end
      StWait: begin
        if (cnt_q == 2'd0) state_d = StDone;
        else               cnt_d   = cnt_q - 2'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  // ACCESS is only ever entered from IDLE, so strobes come straight from the request inputs.
  always_comb begin
    ram_we_d    = 4'b0000;
    ram_wdata_d = 32'h0;
    if (state_d == StAccess && accept && we) begin
      case (funct3[1:0])
        2'b00: begin
          ram_we_d    = 4'b0001 << addr[1:0];
          ram_wdata_d = {4{wdata[7:0]}};
        end
        2'b01: begin
          ram_we_d    = 4'b0011 << addr[1:0];
          ram_wdata_d = {2{wdata[15:0]}};
        end
        default: begin
          ram_we_d    = 4'b1111;
          ram_wdata_d = wdata;
        end
      endcase
    end
  end

  assign ram_addr_d = (accept && !illegal) ? addr[WADDR_W+1:2] : ram_addr;

  always_comb begin
    shifted = ram_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ext = {24'h0, shifted[7:0]};
      3'b101:  ext = {16'h0, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  assign rdata_d = (state_q == StWait && cnt_q == 2'd0) ? ext : rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= 2'd0;
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= 32'h0;
      ram_en    <= 1'b0;
      ram_we    <= 4'b0000;
      ram_addr  <= '0;
      ram_wdata <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      if (accept) begin
        we_q  <= we;
        f3_q  <= funct3;
        off_q <= addr[1:0];
      end
      busy      <= (state_d != StIdle);
      done      <= (state_d == StDone);
      err       <= accept && illegal;
      rdata     <= rdata_d;
      ram_en    <= (state_d == StAccess);
      ram_we    <= ram_we_d;
      ram_addr  <= ram_addr_d;
      ram_wdata <= ram_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with RD_LATENCY=2 and a latency-accurate RAM model.
module tb_mem_access_unit;

  logic        clk;
  logic        reset_n;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int total = 0;
  int bad   = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  int en0;
  int dn0;

  logic [1:0]  pipe;
  logic [31:0] mem_word;

  mem_access_unit #(
    .RD_LATENCY(2),
    .WADDR_W   (14)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .we       (we),
    .funct3   (funct3),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .rdata    (rdata),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read data is valid only in the cycle two edges after ram_en; garbage otherwise.
  always @(posedge clk) pipe <= {pipe[0], ram_en};
  assign ram_rdata = (pipe[1] === 1'b1) ? mem_word : 32'h5A5A5A5A;

  always @(posedge clk) begin
    if (ram_en === 1'b1) en_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, {31'h0, busy}, 32'h0);
    chk({tag, ".done"}, {31'h0, done}, 32'h0);
    chk({tag, ".err"}, {31'h0, err}, 32'h0);
    chk({tag, ".rdata"}, rdata, 32'h0);
    chk({tag, ".ram_en"}, {31'h0, ram_en}, 32'h0);
    chk({tag, ".ram_we"}, {28'h0, ram_we}, 32'h0);
    chk({tag, ".ram_addr"}, {18'h0, ram_addr}, 32'h0);
    chk({tag, ".ram_wdata"}, ram_wdata, 32'h0);
  endtask

  // Presents a request for one cycle; returns at the middle of cycle 1.
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    mem_word = 32'h80FF7F01;
    #2 reset_n = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // SB
    issue(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5);
    chk("sb.c1.ram_en", {31'h0, ram_en}, 32'h1);
    chk("sb.c1.ram_we", {28'h0, ram_we}, 32'h8);
    chk("sb.c1.ram_wdata", ram_wdata, 32'hA5A5A5A5);
    chk("sb.c1.ram_addr", {18'h0, ram_addr}, 32'h400);
    chk("sb.c1.busy", {31'h0, busy}, 32'h1);
    chk("sb.c1.done", {31'h0, done}, 32'h0);
    @(negedge clk);
    chk("sb.c2.done", {31'h0, done}, 32'h1);
    chk("sb.c2.err", {31'h0, err}, 32'h0);
    chk("sb.c2.ram_we", {28'h0, ram_we}, 32'h0);
    chk("sb.c2.ram_wdata", ram_wdata, 32'h0);
    chk("sb.c2.busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    chk("sb.c3.busy", {31'h0, busy}, 32'h0);
    chk("sb.c3.done", {31'h0, done}, 32'h0);

    // SH upper half
    issue(1'b1, 3'b001, 32'h0000_1002, 32'h0000_BEEF);
    chk("sh.ram_we", {28'h0, ram_we}, 32'hC);
    chk("sh.ram_wdata", ram_wdata, 32'hBEEFBEEF);
    @(negedge clk);
    chk("sh.done", {31'h0, done}, 32'h1);

    // LB
    issue(1'b0, 3'b000, 32'h0000_1003, 32'h0);
    chk("lb.c1.ram_en", {31'h0, ram_en}, 32'h1);
    chk("lb.c1.ram_we", {28'h0, ram_we}, 32'h0);
    @(negedge clk);
    chk("lb.c2.done", {31'h0, done}, 32'h0);
    @(negedge clk);
    chk("lb.c3.done", {31'h0, done}, 32'h0);
    chk("lb.c3.busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    chk("lb.c4.done", {31'h0, done}, 32'h1);
    chk("lb.c4.err", {31'h0, err}, 32'h0);
    chk("lb.c4.rdata", rdata, 32'hFFFFFF80);

    // LBU
    issue(1'b0, 3'b100, 32'h0000_1003, 32'h0);
    repeat (3) @(negedge clk);
    chk("lbu.done", {31'h0, done}, 32'h1);
    chk("lbu.rdata", rdata, 32'h00000080);

    // LH
    issue(1'b0, 3'b001, 32'h0000_1002, 32'h0);
    repeat (3) @(negedge clk);
    chk("lh.done", {31'h0, done}, 32'h1);
    chk("lh.rdata", rdata, 32'hFFFF80FF);

    // Misaligned LW
    en0 = en_cnt;
    issue(1'b0, 3'b010, 32'h0000_1002, 32'h0);
    chk("lw_mis.done", {31'h0, done}, 32'h1);
    chk("lw_mis.err", {31'h0, err}, 32'h1);
    chk("lw_mis.ram_en", {31'h0, ram_en}, 32'h0);
    @(negedge clk);
    chk("lw_mis.c2.done", {31'h0, done}, 32'h0);
    chk("lw_mis.c2.err", {31'h0, err}, 32'h0);
    chk("lw_mis.rdata", rdata, 32'hFFFF80FF);
    chk("lw_mis.en_cnt", en_cnt - en0, 0);

    // req held high for the whole load, with store fields that must have no effect
    mem_word = 32'h12345678;
    en0 = en_cnt;
    dn0 = done_cnt;
    issue(1'b0, 3'b010, 32'h0000_1004, 32'h0);
    req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h0000_2000; wdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("spam.c2.ram_we", {28'h0, ram_we}, 32'h0);
    @(negedge clk);
    chk("spam.c3.done", {31'h0, done}, 32'h0);
    @(negedge clk);
    chk("spam.c4.done", {31'h0, done}, 32'h1);
    chk("spam.c4.rdata", rdata, 32'h12345678);
    req = 1'b0;
    issue(1'b1, 3'b010, 32'h0000_1008, 32'hCAFEF00D);
    chk("b2b.ram_en", {31'h0, ram_en}, 32'h1);
    chk("b2b.ram_we", {28'h0, ram_we}, 32'hF);
    chk("b2b.ram_wdata", ram_wdata, 32'hCAFEF00D);
    chk("b2b.ram_addr", {18'h0, ram_addr}, 32'h402);
    @(negedge clk);
    chk("b2b.done", {31'h0, done}, 32'h1);
    @(negedge clk);
    chk("b2b.rdata", rdata, 32'h12345678);
    chk("spam.en_cnt", en_cnt - en0, 2);
    chk("spam.done_cnt", done_cnt - dn0, 2);

    // Illegal funct3 load and SBU
    en0 = en_cnt;
    issue(1'b0, 3'b011, 32'h0000_1000, 32'h0);
    chk("f3_011.done", {31'h0, done}, 32'h1);
    chk("f3_011.err", {31'h0, err}, 32'h1);
    @(negedge clk);
    issue(1'b1, 3'b100, 32'h0000_1000, 32'h0000_0055);
    chk("sbu.done", {31'h0, done}, 32'h1);
    chk("sbu.err", {31'h0, err}, 32'h1);
    chk("sbu.ram_we", {28'h0, ram_we}, 32'h0);
    @(negedge clk);
    chk("illegal.en_cnt", en_cnt - en0, 0);
    chk("illegal.rdata", rdata, 32'h12345678);

    // Reset during WAIT of a load
    issue(1'b0, 3'b000, 32'h0000_1000, 32'h0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_zero("rst_wait");
    @(negedge clk);
    reset_n = 1'b1;

    // Reset during ACCESS of a store: strobes must drop without waiting for a clock
    issue(1'b1, 3'b010, 32'h0000_1000, 32'h11223344);
    chk("rst_acc.pre.ram_we", {28'h0, ram_we}, 32'hF);
    reset_n = 1'b0;
    #1;
    chk_zero("rst_acc");
    @(negedge clk);
    reset_n = 1'b1;
    dn0 = done_cnt;
    repeat (4) @(negedge clk);
    chk("rst_acc.busy", {31'h0, busy}, 32'h0);
    chk("rst_acc.ram_we", {28'h0, ram_we}, 32'h0);
    chk("rst_acc.done_cnt", done_cnt - dn0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
